// File: rtl/ecc_page_encode_ctrl.sv
// ecc_page_encode_ctrl
// Sequencing controller for the shared 128-bit page ECC encoder.
// Words are packed into 8-word pages (assemble), each page is issued to the
// encoder with a one-cycle enable (issue), and the resulting 8-bit code is
// written to the ECC side-memory at the page address (write). Each stage holds
// at most one page. A stage moves forward only when the stage after it is free
// in the same cycle.

module ecc_page_encode_ctrl #(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_data,
   input  logic              in_last,
   input  logic [ADDR_W-1:0] in_page,
   output logic              enc_enable,
   output logic [127:0]      enc_data,
   input  logic [7:0]        enc_code,
   output logic              ecc_wr_en,
   output logic [ADDR_W-1:0] ecc_wr_addr,
   output logic [7:0]        ecc_wr_data,
   input  logic              ecc_wr_ready,
   output logic              busy
);

   // Assemble stage
   logic [15:0]       r_a_buf [8];
   logic [2:0]        r_a_cnt;
   logic [ADDR_W-1:0] r_a_addr;
   logic              r_a_full;

   // Issue stage
   logic              r_i_vld;
   logic [127:0]      r_i_data;
   logic [ADDR_W-1:0] r_i_addr;

   // Write stage
   logic              r_w_vld;
   logic [ADDR_W-1:0] r_w_addr;

   logic              w_w_free;
   logic              w_issue;
   logic              w_i_free;
   logic              w_xfer;
   logic              w_accept;
   logic              w_complete;
   logic [127:0]      w_a_flat;

   // Advance conditions. They are evaluated from the write stage back towards the input.
   assign w_w_free   = !r_w_vld || ecc_wr_ready;
   assign w_issue    = r_i_vld && w_w_free;
   assign w_i_free   = !r_i_vld || w_issue;
   assign w_xfer     = r_a_full && w_i_free;
   assign in_ready   = !r_a_full || w_i_free;
   assign w_accept   = in_valid && in_ready;
   assign w_complete = w_accept && ((r_a_cnt == 3'd7) || in_last);

   assign enc_enable  = w_issue;
   assign enc_data    = r_i_data;
   assign ecc_wr_en   = r_w_vld;
   assign ecc_wr_addr = r_w_addr;
   assign ecc_wr_data = enc_code;
   assign busy        = (r_a_cnt != 3'd0) || r_a_full || r_i_vld || r_w_vld;

   // Flatten the assembly buffer into the encoder operand layout (slot i at bits 16i+15:16i).
   always_comb begin
      // NOTE: a default is assigned before the loop so every bit is driven on every path and no latch is inferred.
      w_a_flat = '0;
      for (int i = 0; i < 8; i++) begin
         w_a_flat[16*i +: 16] = r_a_buf[i];
      end
   end

   // Assemble stage: slot writes, word count, page address and full flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the buffer is reset, and cleared again on every transfer, because zero is the padding value for short pages.
         for (int i = 0; i < 8; i++) begin
            r_a_buf[i] <= '0;
         end
         r_a_cnt  <= '0;
         r_a_addr <= '0;
         r_a_full <= 1'b0;
      end else begin
         if (w_xfer) begin
            for (int i = 0; i < 8; i++) begin
               r_a_buf[i] <= '0;
            end
         end
         // NOTE: a word accepted in a transfer cycle overrides the clear of slot 0, because the later non-blocking assignment wins.
         if (w_accept) begin
            r_a_buf[r_a_cnt] <= in_data;
            if (r_a_cnt == 3'd0) begin
               r_a_addr <= in_page;
            end
            r_a_cnt <= w_complete ? 3'd0 : r_a_cnt + 3'd1;
         end
         if (w_complete) begin
            r_a_full <= 1'b1;
         end else if (w_xfer) begin
            r_a_full <= 1'b0;
         end
      end
   end

   // Issue stage: take a full page from assembly, or drain it when the encoder is enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_i_vld  <= 1'b0;
         r_i_data <= '0;
         r_i_addr <= '0;
      end else if (w_xfer) begin
         r_i_vld  <= 1'b1;
         r_i_data <= w_a_flat;
         r_i_addr <= r_a_addr;
      end else if (w_issue) begin
         r_i_vld  <= 1'b0;
      end
   end

   // Write stage: hold the request until the ECC memory accepts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_vld  <= 1'b0;
         r_w_addr <= '0;
      end else if (w_issue) begin
         r_w_vld  <= 1'b1;
         r_w_addr <= r_i_addr;
      end else if (w_w_free) begin
         r_w_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ecc_page_encode_ctrl.sv
// tb_ecc_page_encode_ctrl
// Bench for ecc_page_encode_ctrl. It contains a behavioural encoder whose code
// register updates on enc_enable. It also keeps a page-level reference model:
// a queue of accepted pages with their expected operand, address and code. A
// monitor runs on every falling edge and checks the DUT against that model.

module tb_ecc_page_encode_ctrl;

   localparam int ADDR_W = 11;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [15:0]       in_data = '0;
   logic              in_last = 1'b0;
   logic [ADDR_W-1:0] in_page = '0;
   logic              enc_enable;
   logic [127:0]      enc_data;
   logic [7:0]        enc_code;
   logic              ecc_wr_en;
   logic [ADDR_W-1:0] ecc_wr_addr;
   logic [7:0]        ecc_wr_data;
   logic              ecc_wr_ready = 1'b1;
   logic              busy;

   int n_cmp = 0;
   int n_mis = 0;
   bit rand_done = 1'b0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [127:0]      data;
      logic [7:0]        code;
   } page_t;

   page_t             iss_q[$];
   page_t             wr_q[$];
   logic [15:0]       m_words [8];
   int                m_cnt = 0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [7:0]        prev_data = '0;

   always #5 clk = ~clk;

   ecc_page_encode_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_page      (in_page),
      .enc_enable   (enc_enable),
      .enc_data     (enc_data),
      .enc_code     (enc_code),
      .ecc_wr_en    (ecc_wr_en),
      .ecc_wr_addr  (ecc_wr_addr),
      .ecc_wr_data  (ecc_wr_data),
      .ecc_wr_ready (ecc_wr_ready),
      .busy         (busy)
   );

   // Encoder code: XOR of (i+1) over every set operand bit i.
   function automatic logic [7:0] code_of(input logic [127:0] d);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 128; i++) begin
         if (d[i]) c = c ^ 8'(i + 1);
      end
      return c;
   endfunction

   // Behavioural shared encoder: the code register updates the cycle after enable.
   always @(posedge clk or posedge rst) begin
      if (rst) enc_code <= '0;
      else if (enc_enable) enc_code <= code_of(enc_data);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One falling-edge step. Compare the outputs against the model, then fold in
   // the handshakes that will take effect at the next rising edge.
   task automatic monitor_step();
      page_t pg;
      if (rst) begin
         iss_q.delete();
         wr_q.delete();
         m_cnt = 0;
         for (int i = 0; i < 8; i++) m_words[i] = '0;
         prev_stall = 1'b0;
         return;
      end
      check("busy", 128'(busy), 128'((m_cnt != 0) || (wr_q.size() != 0)));
      if (prev_stall) begin
         check("stall_hold_en", 128'(ecc_wr_en), 128'(1));
         check("stall_hold_addr", 128'(ecc_wr_addr), 128'(prev_addr));
         check("stall_hold_data", 128'(ecc_wr_data), 128'(prev_data));
      end
      if (ecc_wr_en && !ecc_wr_ready) check("issue_while_stalled", 128'(enc_enable), 128'(0));
      if (enc_enable) begin
         if (iss_q.size() == 0) check("spurious_issue", 128'(enc_enable), 128'(0));
         else begin
            check("issue_data", enc_data, iss_q[0].data);
            void'(iss_q.pop_front());
         end
      end
      if (ecc_wr_en && ecc_wr_ready) begin
         if (wr_q.size() == 0) check("spurious_write", 128'(ecc_wr_en), 128'(0));
         else begin
            check("write_addr", 128'(ecc_wr_addr), 128'(wr_q[0].addr));
            check("write_code", 128'(ecc_wr_data), 128'(wr_q[0].code));
            void'(wr_q.pop_front());
         end
      end
      if (in_valid && in_ready) begin
         if (m_cnt == 0) m_addr = in_page;
         m_words[m_cnt] = in_data;
         if (m_cnt == 7 || in_last) begin
            pg.addr = m_addr;
            for (int i = 0; i < 8; i++) pg.data[16*i +: 16] = m_words[i];
            pg.code = code_of(pg.data);
            iss_q.push_back(pg);
            wr_q.push_back(pg);
            for (int i = 0; i < 8; i++) m_words[i] = '0;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      prev_stall = ecc_wr_en && !ecc_wr_ready;
      prev_addr  = ecc_wr_addr;
      prev_data  = ecc_wr_data;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   // Present one word starting at rising edge + 1 and hold it until it is accepted.
   // waits counts the falling edges at which in_ready was low.
   task automatic drive_word(input logic [15:0] d, input logic l, input logic [ADDR_W-1:0] p,
                             output int waits);
      waits = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_page  = p;
      @(negedge clk);
      while (!in_ready && waits < 300) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_for_wr(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!ecc_wr_en && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_wr_seen"}, 128'(ecc_wr_en), 128'(1));
   endtask

   task automatic wait_for_en(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!enc_enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({name, "_en_seen"}, 128'(enc_enable), 128'(1));
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 128'(busy), 128'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      #1 rst = 1'b1;
      #1;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_enc_enable", 128'(enc_enable), 128'(0));
      check("rst_enc_data", enc_data, 128'(0));
      check("rst_wr_en", 128'(ecc_wr_en), 128'(0));
      check("rst_wr_addr", 128'(ecc_wr_addr), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Full page, last word 8000 on slot 7 together with in_last
      for (int i = 0; i < 8; i++) drive_word((i == 7) ? 16'h8000 : 16'h0000, i == 7, 11'h005, w);
      @(negedge clk);
      check("full_no_enable_t1", 128'(enc_enable), 128'(0));
      @(negedge clk);
      check("full_enable_t2", 128'(enc_enable), 128'(1));
      check("full_word7", 128'(enc_data[127:112]), 128'(16'h8000));
      check("full_low_words", 128'(enc_data[111:0]), 128'(0));
      @(negedge clk);
      check("full_wr_en_t3", 128'(ecc_wr_en), 128'(1));
      check("full_wr_addr", 128'(ecc_wr_addr), 128'(11'h005));
      check("full_wr_data", 128'(ecc_wr_data), 128'(8'h80));
      drain("full");

      // One-word page
      drive_word(16'h0001, 1'b1, 11'h00A, w);
      @(negedge clk);
      check("short_no_enable_t1", 128'(enc_enable), 128'(0));
      @(negedge clk);
      check("short_enable_t2", 128'(enc_enable), 128'(1));
      check("short_enc_data", enc_data, 128'h1);
      @(negedge clk);
      check("short_wr_en_t3", 128'(ecc_wr_en), 128'(1));
      check("short_wr_addr", 128'(ecc_wr_addr), 128'(11'h00A));
      check("short_wr_data", 128'(ecc_wr_data), 128'(8'h01));
      drain("short");

      // Back-to-back one-word pages
      drive_word(16'h0004, 1'b1, 11'h001, w);
      check("b2b_ready_first", 128'(w), 128'(0));
      drive_word(16'h0001, 1'b1, 11'h002, w);
      check("b2b_ready_second", 128'(w), 128'(0));
      wait_for_wr("b2b");
      check("b2b_addr_1", 128'(ecc_wr_addr), 128'(11'h001));
      check("b2b_data_1", 128'(ecc_wr_data), 128'(8'h03));
      @(negedge clk);
      check("b2b_wr_en_2", 128'(ecc_wr_en), 128'(1));
      check("b2b_addr_2", 128'(ecc_wr_addr), 128'(11'h002));
      check("b2b_data_2", 128'(ecc_wr_data), 128'(8'h01));
      drain("b2b");

      // Back-pressure with continuous all-ones pages
      ecc_wr_ready = 1'b0;
      fork
         begin
            int wt;
            for (int p = 0; p < 4; p++)
               for (int i = 0; i < 8; i++) drive_word(16'hFFFF, i == 7, ADDR_W'(16 + p), wt);
         end
         begin
            int n;
            n = 0;
            @(negedge clk);
            while (in_ready && n < 200) begin
               @(negedge clk);
               n++;
            end
            check("bp_in_ready_fell", 128'(in_ready), 128'(0));
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               check("bp_wr_en_held", 128'(ecc_wr_en), 128'(1));
               check("bp_addr_stable", 128'(ecc_wr_addr), 128'(11'h010));
               check("bp_no_enable", 128'(enc_enable), 128'(0));
               check("bp_in_ready_low", 128'(in_ready), 128'(0));
               check("bp_code", 128'(ecc_wr_data), 128'(8'h80));
            end
            @(posedge clk);
            #1 ecc_wr_ready = 1'b1;
         end
      join
      drain("bp");

      // Padding: 3-word page, then 1-word page, both issued back to back
      drive_word(16'hAAAA, 1'b0, 11'h123, w);
      drive_word(16'h5555, 1'b0, 11'h123, w);
      drive_word(16'hBEEF, 1'b1, 11'h123, w);
      drive_word(16'h1234, 1'b1, 11'h456, w);
      wait_for_en("pad");
      check("pad_slots_3_7_zero", 128'(enc_data[127:48]), 128'(0));
      check("pad_slots_0_2", 128'(enc_data[47:0]), 128'({16'hBEEF, 16'h5555, 16'hAAAA}));
      @(negedge clk);
      check("pad_second_enable", 128'(enc_enable), 128'(1));
      check("pad_no_residue", 128'(enc_data[127:16]), 128'(0));
      check("pad_second_slot0", 128'(enc_data[15:0]), 128'(16'h1234));
      drain("pad");

      // Reset with all three stages full
      ecc_wr_ready = 1'b0;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < 8; i++) drive_word(16'($urandom), i == 7, ADDR_W'(32 + p), w);
      @(negedge clk);
      check("mid_busy_before", 128'(busy), 128'(1));
      check("mid_in_ready_before", 128'(in_ready), 128'(0));
      check("mid_wr_en_before", 128'(ecc_wr_en), 128'(1));
      #2 rst = 1'b1;
      #1;
      check("mid_wr_en_async", 128'(ecc_wr_en), 128'(0));
      check("mid_enable", 128'(enc_enable), 128'(0));
      check("mid_enc_data", enc_data, 128'(0));
      check("mid_wr_addr", 128'(ecc_wr_addr), 128'(0));
      check("mid_wr_data", 128'(ecc_wr_data), 128'(0));
      check("mid_busy", 128'(busy), 128'(0));
      check("mid_in_ready", 128'(in_ready), 128'(1));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      ecc_wr_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("post_rst_no_write", 128'(ecc_wr_en), 128'(0));
      end
      @(posedge clk);
      #1;
      drive_word(16'h0040, 1'b1, 11'h07F, w);
      wait_for_wr("post_rst");
      check("post_rst_addr", 128'(ecc_wr_addr), 128'(11'h07F));
      check("post_rst_data", 128'(ecc_wr_data), 128'(8'h07));
      drain("post_rst");

      // Randomized pages against the reference model, with random back-pressure
      fork
         begin
            int len;
            int wt;
            bit last8;
            logic [ADDR_W-1:0] pa;
            logic [15:0] d;
            for (int p = 0; p < 60; p++) begin
               len   = int'($urandom_range(1, 8));
               last8 = 1'($urandom);
               pa    = ADDR_W'($urandom);
               for (int i = 0; i < len; i++) begin
                  d = (($urandom % 5) == 0) ? 16'h0000 : 16'($urandom);
                  drive_word(d, (i == len - 1) && (len < 8 || last8), pa, wt);
                  if (($urandom % 4) == 0) begin
                     repeat (int'($urandom_range(1, 3))) @(posedge clk);
                     #1;
                  end
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 ecc_wr_ready = (($urandom % 4) != 0);
            end
            ecc_wr_ready = 1'b1;
         end
      join
      drain("random");
      check("final_writes_outstanding", 128'(wr_q.size()), 128'(0));
      check("final_issues_outstanding", 128'(iss_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
